// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: owns the register file write port; zero sweep after reset, then WB/secondary arbitration with anti-starvation
module rf_write_arbiter #(
  parameter int NREG = 32,
  parameter int XLEN = 32,
  parameter int AW = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            WB_EN,
  input  logic [AW-1:0]   WB_WA,
  input  logic [XLEN-1:0] WB_WD,
  input  logic            SEC_VALID,
  input  logic [AW-1:0]   SEC_WA,
  input  logic [XLEN-1:0] SEC_WD,
  output logic            SEC_READY,
  output logic            PIPE_STALL,
  output logic            INIT_BUSY,
  output logic            RF_EN,
  output logic [AW-1:0]   RF_WA,
  output logic [XLEN-1:0] RF_WD
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t fsm, fsm_nxt;
  logic [AW-1:0] clr_cnt;
  logic [SW-1:0] starve_cnt;
  logic wb_req, sec_req, sec_drop, force_sec, grant_sec, grant_wb;
  assign wb_req    = WB_EN & (WB_WA != '0);
  assign sec_req   = SEC_VALID & (SEC_WA != '0);
  assign sec_drop  = SEC_VALID & (SEC_WA == '0);
  assign force_sec = sec_req & (starve_cnt == SW'(STARVE_MAX));
  assign grant_sec = sec_req & (force_sec | !wb_req);
  assign grant_wb  = wb_req & !grant_sec;
  always_ff @(posedge CLK) begin
    if (RST) begin
      fsm <= CLEAR;
      clr_cnt <= AW'(1);
      starve_cnt <= '0;
    end else begin
      fsm <= fsm_nxt;
      if (fsm == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (fsm == CLEAR || !SEC_VALID || SEC_READY) starve_cnt <= '0;
      else if (sec_req && starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
    end
  end
  always_comb begin
    fsm_nxt = fsm;
    INIT_BUSY = 1'b1;
    PIPE_STALL = 1'b1;
    SEC_READY = 1'b0;
    RF_EN = 1'b1;
    RF_WA = clr_cnt;
    RF_WD = '0;
    if (fsm == CLEAR) begin
      fsm_nxt = (clr_cnt == AW'(NREG - 1)) ? RUN : CLEAR;
    end else begin
      INIT_BUSY = 1'b0;
      SEC_READY = sec_drop | grant_sec;
      PIPE_STALL = grant_sec & wb_req;
      RF_EN = grant_sec | grant_wb;
      RF_WA = grant_sec ? SEC_WA : grant_wb ? WB_WA : '0;
      RF_WD = grant_sec ? SEC_WD : grant_wb ? WB_WD : '0;
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: scoreboard bench with a behavioural arbiter model and shadow register files
module tb_rf_write_arbiter;
  logic CLK = 1'b0;
  logic RST, WB_EN, SEC_VALID, SEC_READY, PIPE_STALL, INIT_BUSY, RF_EN;
  logic [4:0] WB_WA, SEC_WA, RF_WA;
  logic [31:0] WB_WD, SEC_WD, RF_WD;
  always #5 CLK = ~CLK;
  rf_write_arbiter dut (
    .CLK(CLK), .RST(RST), .WB_EN(WB_EN), .WB_WA(WB_WA), .WB_WD(WB_WD),
    .SEC_VALID(SEC_VALID), .SEC_WA(SEC_WA), .SEC_WD(SEC_WD), .SEC_READY(SEC_READY),
    .PIPE_STALL(PIPE_STALL), .INIT_BUSY(INIT_BUSY), .RF_EN(RF_EN), .RF_WA(RF_WA), .RF_WD(RF_WD)
  );
  typedef struct packed {
    logic en;
    logic [4:0] wa;
    logic [31:0] wd;
    logic rdy;
    logic stall;
    logic busy;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  logic m_clear;
  logic [4:0] m_clr;
  int m_starve;
  logic last_stall, last_pend;
  logic [31:0] rf_dut[32], rf_exp[32];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  function automatic exp_t model();
    exp_t e;
    logic wbr, secr;
    e = '0;
    if (m_clear) begin
      e.en = 1'b1;
      e.wa = m_clr;
      e.stall = 1'b1;
      e.busy = 1'b1;
    end else begin
      wbr = WB_EN && WB_WA != 0;
      secr = SEC_VALID && SEC_WA != 0;
      if (SEC_VALID && SEC_WA == 0) e.rdy = 1'b1;
      if (secr && m_starve == 4) begin
        e.en = 1'b1; e.wa = SEC_WA; e.wd = SEC_WD; e.rdy = 1'b1; e.stall = wbr;
      end else if (wbr) begin
        e.en = 1'b1; e.wa = WB_WA; e.wd = WB_WD;
      end else if (secr) begin
        e.en = 1'b1; e.wa = SEC_WA; e.wd = SEC_WD; e.rdy = 1'b1;
      end
    end
    return e;
  endfunction
  task automatic step(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic sv, input logic [4:0] sa, input logic [31:0] sd, input string tag);
    exp_t e;
    RST = rst; WB_EN = we; WB_WA = wa; WB_WD = wd; SEC_VALID = sv; SEC_WA = sa; SEC_WD = sd;
    q.push_back(model());
    @(negedge CLK);
    e = q.pop_front();
    chk({tag, ".en"}, 32'(RF_EN), 32'(e.en));
    chk({tag, ".wa"}, 32'(RF_WA), 32'(e.wa));
    chk({tag, ".wd"}, RF_WD, e.wd);
    chk({tag, ".rdy"}, 32'(SEC_READY), 32'(e.rdy));
    chk({tag, ".stall"}, 32'(PIPE_STALL), 32'(e.stall));
    chk({tag, ".busy"}, 32'(INIT_BUSY), 32'(e.busy));
    if (RF_EN === 1'b1) rf_dut[RF_WA] = RF_WD;
    if (e.en) rf_exp[e.wa] = e.wd;
    @(posedge CLK);
    if (rst) begin
      m_clear = 1'b1; m_clr = 5'd1; m_starve = 0;
    end else if (m_clear) begin
      if (m_clr == 5'd31) m_clear = 1'b0;
      m_clr = m_clr + 5'd1;
      m_starve = 0;
    end else if (!sv || e.rdy) m_starve = 0;
    else if (sa != 0 && m_starve < 4) m_starve++;
    last_stall = e.stall && !e.busy;
    last_pend = sv && !e.rdy && !e.busy;
    #1;
  endtask
  task automatic sweep(input logic sv, input string tag);
    for (int i = 0; i < 31; i++) step(1'b0, 1'b1, 5'(i), 32'($urandom), sv, 5'd9, 32'h55, tag);
  endtask
  initial begin
    logic we, sv;
    logic [4:0] wa, sa;
    logic [31:0] wd, sd;
    for (int i = 0; i < 32; i++) begin rf_dut[i] = 32'hA5A5A5A5; rf_exp[i] = 32'hA5A5A5A5; end
    RST = 1'b1; WB_EN = 0; WB_WA = 0; WB_WD = 0; SEC_VALID = 0; SEC_WA = 0; SEC_WD = 0;
    @(posedge CLK); #1;
    m_clear = 1'b1; m_clr = 5'd1; m_starve = 0; last_stall = 0; last_pend = 0;
    step(1'b1, 0, 0, 0, 0, 0, 0, "rst0");
    step(1'b1, 0, 0, 0, 0, 0, 0, "rst1");
    sweep(1'b1, "sweep");
    step(1'b0, 0, 0, 0, 0, 0, 0, "idle");
    for (int i = 1; i < 32; i++) chk($sformatf("zero_x%0d", i), rf_dut[i], 32'h0);
    step(1'b0, 1, 5'd3, 32'hDEADBEEF, 0, 0, 0, "wb3");
    chk("read_x3", rf_dut[3], 32'hDEADBEEF);
    for (int i = 0; i < 6; i++) step(1'b0, 1, 5'd7, 32'h700 + 32'(i), 1, 5'd9, 32'h1234, "starve");
    chk("read_x9", rf_dut[9], 32'h1234);
    step(1'b0, 1, 5'd0, 32'h1, 0, 0, 0, "wb_x0");
    step(1'b0, 1, 5'd4, 32'h44, 1, 5'd0, 32'h99, "sec_x0");
    step(1'b0, 0, 0, 0, 1, 5'd31, 32'hFFFFFFFF, "sec31");
    step(1'b0, 1, 5'd5, 32'h5, 1, 5'd6, 32'h66, "wd0");
    step(1'b0, 1, 5'd5, 32'h6, 1, 5'd6, 32'h66, "wd1");
    step(1'b0, 1, 5'd5, 32'h7, 0, 5'd6, 32'h66, "wd2");
    for (int i = 0; i < 6; i++) step(1'b0, 1, 5'd5, 32'h50 + 32'(i), 1, 5'd6, 32'h67, "wd_re");
    step(1'b1, 0, 0, 0, 0, 0, 0, "rstA");
    for (int i = 0; i < 11; i++) step(1'b0, 0, 0, 0, 0, 0, 0, "part");
    step(1'b1, 0, 0, 0, 0, 0, 0, "rst12");
    sweep(1'b0, "resweep");
    for (int i = 0; i < 3; i++) step(1'b0, 1, 5'd2, 32'h22, 1, 5'd8, 32'h88, "pre");
    step(1'b1, 1, 5'd2, 32'h22, 1, 5'd8, 32'h88, "rst_st");
    sweep(1'b1, "sweep_sec");
    step(1'b0, 1, 5'd2, 32'h23, 1, 5'd8, 32'h88, "post");
    for (int n = 0; n < 300; n++) begin
      if (last_stall) begin
        we = WB_EN; wa = WB_WA; wd = WB_WD;
      end else begin
        we = 1'($urandom_range(0, 3) != 0); wa = 5'($urandom_range(0, 7)); wd = $urandom;
      end
      if (last_pend && $urandom_range(0, 9) != 0) begin
        sv = 1'b1; sa = SEC_WA; sd = SEC_WD;
      end else begin
        sv = 1'($urandom_range(0, 2) != 0); sa = 5'($urandom_range(0, 7)); sd = $urandom;
      end
      step(1'b0, we, wa, wd, sv, sa, sd, "rand");
    end
    for (int i = 0; i < 32; i++) chk($sformatf("rf_x%0d", i), rf_dut[i], rf_exp[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
